// File: rtl/hamming_pkg.sv
// ---------------------------------------------------------------------------
// hamming_pkg
// Shared helpers for the Hamming / extended-Hamming (SECDED) encoder.
//   calcParW      : number of Hamming parity bits needed for a data width
//   calcCodeW     : full codeword width (data + parity + overall-parity bit)
//   posToDataIdx  : which data bit lives at a codeword position (-1 = none)
//   encodeWord    : pure combinational encoder, sized for the widest word
// ---------------------------------------------------------------------------
package hamming_pkg;

    localparam int MAX_DATA_W = 57;
    localparam int MAX_PAR_W  = 6;
    localparam int MAX_CODE_W = 64;

    // Smallest r with 2^r >= dataW + r + 1. Scanning downward leaves the
    // smallest qualifying r in the result.
    function automatic int calcParW(input int dataW);
        int r;
        r = MAX_PAR_W + 1;
        for (int i = MAX_PAR_W; i >= 1; i--) begin
            if ((1 << i) >= dataW + i + 1) begin
                r = i;
            end
        end
        return r;
    endfunction

    function automatic int calcCodeW(input int dataW);
        return dataW + calcParW(dataW) + 1;
    endfunction

    // Position 0 and the powers of two carry parity. Every other position
    // carries the next data bit in ascending order. The data index is
    // therefore the position minus one, minus the number of parity slots
    // (powers of two) that come at or below it.
    function automatic int posToDataIdx(input int pos);
        int nPow;
        if (pos <= 0) begin
            return -1;
        end
        if ((pos & (pos - 1)) == 0) begin
            return -1;
        end
        nPow = 0;
        for (int k = 0; k <= MAX_PAR_W; k++) begin
            if ((1 << k) <= pos) begin
                nPow++;
            end
        end
        return pos - 1 - nPow;
    endfunction

    // Scatter the data bits, then fill each parity slot 2^k with the XOR of
    // the data positions whose index has bit k set. Position 0 is the XOR of
    // everything else when the extended code is selected.
    function automatic logic [MAX_CODE_W-1:0] encodeWord(
        input logic [MAX_DATA_W-1:0] data,
        input int                    dataW,
        input logic                  secdedEn
    );
        logic [MAX_CODE_W-1:0] code;
        int                    parW;
        int                    codeW;
        int                    idx;
        int                    pw;
        logic                  p;
        parW  = calcParW(dataW);
        codeW = dataW + parW + 1;
        code  = '0;
        for (int pos = 1; pos < MAX_CODE_W; pos++) begin
            idx = posToDataIdx(pos);
            if (pos < codeW && idx >= 0 && idx < MAX_DATA_W) begin
                code[pos[5:0]] = data[idx[5:0]];
            end
        end
        for (int k = 0; k < MAX_PAR_W; k++) begin
            if (k < parW) begin
                p = 1'b0;
                for (int pos = 1; pos < MAX_CODE_W; pos++) begin
                    if (pos < codeW && ((pos >> k) & 1) != 0 && posToDataIdx(pos) >= 0) begin
                        p = p ^ code[pos[5:0]];
                    end
                end
                pw = 1 << k;
                code[pw[5:0]] = p;
            end
        end
        code[0] = secdedEn ? (^code) : 1'b0;
        return code;
    endfunction

endpackage

// File: rtl/enc_skid_buf.sv
// ---------------------------------------------------------------------------
// enc_skid_buf
// Two-entry first-in first-out skid buffer with a registered ready.
//   clk, reset      : clock, synchronous active-high reset
//   in_valid_i      : producer has a word on in_data_i
//   in_ready_o      : registered, high while fewer than two entries are held
//   in_data_i       : word to store
//   out_valid_o     : at least one entry held; out_data_o is the oldest
//   out_ready_i     : consumer takes the oldest entry this cycle
//   out_data_o      : oldest entry, held stable until it is taken
// ---------------------------------------------------------------------------
module enc_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic [WIDTH-1:0] entry_q [2];
    logic             wrPtr_q;
    logic             rdPtr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             inReady_q;
    logic             push;
    logic             pop;

    assign in_ready_o  = inReady_q;
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = entry_q[rdPtr_q];

    // Work out this cycle's transfers and the occupancy after the edge.
    // A push and a pop together leave the occupancy unchanged, which also
    // covers a simultaneous transfer while both entries are full.
    always_comb begin
        push    = in_valid_i && inReady_q;
        pop     = out_valid_o && out_ready_i;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push && pop) begin
            count_d = count_q - 2'd1;
        end
    end

    // Storage and pointers. Ready is computed from the next occupancy so
    // that it is a flop output yet still exact on every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q   <= '{default: '0};
            wrPtr_q   <= 1'b0;
            rdPtr_q   <= 1'b0;
            count_q   <= 2'd0;
            inReady_q <= 1'b0;
        end else begin
            if (push) begin
                entry_q[wrPtr_q] <= in_data_i;
                wrPtr_q          <= ~wrPtr_q;
            end
            if (pop) begin
                rdPtr_q <= ~rdPtr_q;
            end
            count_q   <= count_d;
            inReady_q <= (count_d != 2'd2);
        end
    end

endmodule

// File: rtl/hamming_secded_enc.sv
// ---------------------------------------------------------------------------
// hamming_secded_enc
// Streaming Hamming / SECDED encoder with optional single-bit error
// injection, a two-entry output skid buffer and a completed-word counter.
//   clk, reset       : clock, synchronous active-high reset
//   in_valid/ready   : input handshake for data_in
//   data_in          : data word, bit 0 is the LSB
//   secded_en        : 1 = extended code, 0 = plain Hamming with bit 0 = 0
//   inj_en, inj_pos  : invert codeword bit inj_pos of this word
//   out_valid/ready  : output handshake for code_out
//   code_out         : codeword, bit i is Hamming position i
//   word_cnt         : completed output handshakes, wraps
// inj_pos carries one bit beyond what is needed to address the codeword so
// that an out-of-range position can be requested; such a request flips
// nothing.
// ---------------------------------------------------------------------------
module hamming_secded_enc
    import hamming_pkg::*;
#(
    parameter  int DATA_W = 4,
    parameter  int CNT_W  = 16,
    localparam int PAR_W  = calcParW(DATA_W),
    localparam int CODE_W = DATA_W + PAR_W + 1,
    localparam int INJ_W  = $clog2(CODE_W) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic              secded_en,
    input  logic              inj_en,
    input  logic [INJ_W-1:0]  inj_pos,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] code_out,
    output logic [CNT_W-1:0]  word_cnt
);

    logic [MAX_DATA_W-1:0] dataWide;
    logic [CODE_W-1:0]     codeInj;
    logic [CNT_W-1:0]      wordCnt_q;
    logic [CNT_W-1:0]      wordCnt_d;

    // Encode the incoming word, then apply the injected flip last so the
    // overall-parity bit is computed over the clean codeword and the stored
    // word carries exactly one error.
    always_comb begin
        dataWide               = '0;
        dataWide[DATA_W-1:0]   = data_in;
        codeInj                = CODE_W'(encodeWord(dataWide, DATA_W, secded_en));
        for (int i = 0; i < CODE_W; i++) begin
            if (inj_en && inj_pos == INJ_W'(i)) begin
                codeInj[i] = ~codeInj[i];
            end
        end
    end

    enc_skid_buf #(
        .WIDTH (CODE_W)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (codeInj),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (code_out)
    );

    // Count every completed output handshake; natural wrap at 2^CNT_W.
    always_comb begin
        wordCnt_d = wordCnt_q;
        if (out_valid && out_ready) begin
            wordCnt_d = wordCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wordCnt_q <= '0;
        end else begin
            wordCnt_q <= wordCnt_d;
        end
    end

    assign word_cnt = wordCnt_q;

endmodule

// File: tb/tb_hamming_secded_enc.sv
// ---------------------------------------------------------------------------
// tb_hamming_secded_enc
// Bench for the Hamming/SECDED encoder. A 4-bit instance with a 4-bit counter
// gets directed vectors plus a short random stretch against a scoreboard;
// 11/26/57-bit instances stream words that are decoded by a syndrome-based
// reference decoder.
// ---------------------------------------------------------------------------
module tb_hamming_secded_enc;

    localparam int CW4  = 8;
    localparam int IW4  = 4;
    localparam int CW11 = 16;
    localparam int IW11 = 5;
    localparam int CW26 = 32;
    localparam int IW26 = 6;
    localparam int CW57 = 64;
    localparam int IW57 = 7;

    typedef struct {
        logic [63:0] data;
        bit          injEn;
        int          injPos;
    } wideRec_t;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      data_in;
    logic            secded_en;
    logic            inj_en;
    logic [IW4-1:0]  inj_pos;
    logic            out_valid;
    logic            out_ready;
    logic [CW4-1:0]  code_out;
    logic [3:0]      word_cnt;

    logic            wValid;
    logic            wSecded;
    logic            wOutReady;

    logic            w11Ready, w11OutValid, w11InjEn;
    logic [10:0]     w11Data;
    logic [IW11-1:0] w11InjPos;
    logic [CW11-1:0] w11Code;
    logic [15:0]     w11Cnt;

    logic            w26Ready, w26OutValid, w26InjEn;
    logic [25:0]     w26Data;
    logic [IW26-1:0] w26InjPos;
    logic [CW26-1:0] w26Code;
    logic [15:0]     w26Cnt;

    logic            w57Ready, w57OutValid, w57InjEn;
    logic [56:0]     w57Data;
    logic [IW57-1:0] w57InjPos;
    logic [CW57-1:0] w57Code;
    logic [15:0]     w57Cnt;

    int              totalChecks = 0;
    int              badChecks   = 0;
    int              cycleCount  = 0;
    logic            rstSampled;

    logic [63:0]     expQ[$];
    int              expCnt      = 0;
    bit              holdActive  = 0;
    logic [63:0]     heldCode;
    wideRec_t        q11[$];
    wideRec_t        q26[$];
    wideRec_t        q57[$];

    hamming_secded_enc #(.DATA_W(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .secded_en(secded_en), .inj_en(inj_en), .inj_pos(inj_pos),
        .out_valid(out_valid), .out_ready(out_ready), .code_out(code_out), .word_cnt(word_cnt)
    );

    hamming_secded_enc #(.DATA_W(11)) dut11 (
        .clk(clk), .reset(reset), .in_valid(wValid), .in_ready(w11Ready),
        .data_in(w11Data), .secded_en(wSecded), .inj_en(w11InjEn), .inj_pos(w11InjPos),
        .out_valid(w11OutValid), .out_ready(wOutReady), .code_out(w11Code), .word_cnt(w11Cnt)
    );

    hamming_secded_enc #(.DATA_W(26)) dut26 (
        .clk(clk), .reset(reset), .in_valid(wValid), .in_ready(w26Ready),
        .data_in(w26Data), .secded_en(wSecded), .inj_en(w26InjEn), .inj_pos(w26InjPos),
        .out_valid(w26OutValid), .out_ready(wOutReady), .code_out(w26Code), .word_cnt(w26Cnt)
    );

    hamming_secded_enc #(.DATA_W(57)) dut57 (
        .clk(clk), .reset(reset), .in_valid(wValid), .in_ready(w57Ready),
        .data_in(w57Data), .secded_en(wSecded), .inj_en(w57InjEn), .inj_pos(w57InjPos),
        .out_valid(w57OutValid), .out_ready(wOutReady), .code_out(w57Code), .word_cnt(w57Cnt)
    );

    // Free-running clock and the bench's own view of reset at each edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        rstSampled <= reset;
        cycleCount++;
    end

    // Number of parity bits from the textbook rule.
    function automatic int tbParW(input int dataW);
        int r;
        r = 1;
        while ((1 << r) < dataW + r + 1) r++;
        return r;
    endfunction

    // Reference encoder: place the data bits, then choose the parity bits so
    // that the XOR of all set positions (the syndrome) becomes zero, set the
    // overall parity for even weight, and finally apply the injected flip.
    function automatic logic [63:0] modelEncode(input logic [63:0] data, input int dataW,
                                                input bit secded, input bit injEn, input int injPos);
        logic [63:0] code;
        int          codeW;
        int          parW;
        int          idx;
        int          syn;
        parW  = tbParW(dataW);
        codeW = dataW + parW + 1;
        code  = '0;
        idx   = 0;
        for (int pos = 1; pos < codeW; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                code[pos] = data[idx];
                idx++;
            end
        end
        syn = 0;
        for (int pos = 1; pos < codeW; pos++) begin
            if (code[pos]) syn = syn ^ pos;
        end
        for (int k = 0; k < parW; k++) begin
            code[1 << k] = syn[k];
        end
        if (secded) code[0] = ^code;
        if (injEn && injPos < codeW) code[injPos] = ~code[injPos];
        return code;
    endfunction

    // Single comparison point: every check is counted here.
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference decoder for the wide instances: syndrome, overall parity and
    // recovered data of a received word.
    task automatic checkWide(input string tag, input logic [63:0] code, input int dataW, input wideRec_t r);
        int          codeW;
        int          syn;
        int          idx;
        bit          par;
        logic [63:0] dat;
        codeW = dataW + tbParW(dataW) + 1;
        syn   = 0;
        par   = 0;
        dat   = '0;
        idx   = 0;
        for (int pos = 0; pos < codeW; pos++) begin
            if (code[pos]) begin
                syn = syn ^ pos;
                par = ~par;
            end
            if (pos > 0 && (pos & (pos - 1)) != 0) begin
                dat[idx] = code[pos];
                idx++;
            end
        end
        if (r.injEn && r.injPos < codeW) begin
            checkOutput({tag, "Syndrome"}, 64'(syn), 64'(r.injPos));
            checkOutput({tag, "ParityErr"}, 64'(par), 64'd1);
        end else begin
            checkOutput({tag, "Syndrome"}, 64'(syn), 64'd0);
            checkOutput({tag, "Parity"}, 64'(par), 64'd0);
            checkOutput({tag, "Data"}, dat, r.data);
        end
    endtask

    // Compare process, mid-cycle: occupancy, ordering, stability and counter
    // of the 4-bit instance against the scoreboard, and decoder checks on the
    // wide instances. Transfers seen here complete at the next rising edge.
    always @(negedge clk) begin
        if (rstSampled === 1'b1) begin
            checkOutput("rstOutValid", 64'(out_valid), 64'd0);
            checkOutput("rstInReady", 64'(in_ready), 64'd0);
            checkOutput("rstWordCnt", 64'(word_cnt), 64'd0);
            checkOutput("rstCodeOut", 64'(code_out), 64'd0);
            checkOutput("rstW11Valid", 64'(w11OutValid), 64'd0);
            expQ.delete();
            q11.delete();
            q26.delete();
            q57.delete();
            expCnt     = 0;
            holdActive = 0;
        end else if (rstSampled === 1'b0) begin
            checkOutput("inReadyOcc", 64'(in_ready), 64'(expQ.size() < 2));
            checkOutput("outValidOcc", 64'(out_valid), 64'(expQ.size() != 0));
            checkOutput("wordCnt", 64'(word_cnt), 64'(expCnt % 16));
            if (holdActive) begin
                checkOutput("holdValid", 64'(out_valid), 64'd1);
                checkOutput("holdCode", 64'(code_out), heldCode);
            end
            if (out_valid === 1'b1 && expQ.size() != 0) begin
                checkOutput("codeOrder", 64'(code_out), expQ[0]);
            end
            checkOutput("w11ValidOcc", 64'(w11OutValid), 64'(q11.size() != 0));
            checkOutput("w26ValidOcc", 64'(w26OutValid), 64'(q26.size() != 0));
            checkOutput("w57ValidOcc", 64'(w57OutValid), 64'(q57.size() != 0));
            if (reset === 1'b0) begin
                holdActive = 0;
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    if (expQ.size() != 0) void'(expQ.pop_front());
                    expCnt++;
                end else if (out_valid === 1'b1) begin
                    holdActive = 1;
                    heldCode   = 64'(code_out);
                end
                if (in_valid === 1'b1 && in_ready === 1'b1) begin
                    expQ.push_back(modelEncode(64'(data_in), 4, secded_en, inj_en, int'(inj_pos)));
                end
                if (w11OutValid === 1'b1 && q11.size() != 0) checkWide("w11", 64'(w11Code), 11, q11.pop_front());
                if (w26OutValid === 1'b1 && q26.size() != 0) checkWide("w26", 64'(w26Code), 26, q26.pop_front());
                if (w57OutValid === 1'b1 && q57.size() != 0) checkWide("w57", 64'(w57Code), 57, q57.pop_front());
                if (wValid === 1'b1 && w11Ready === 1'b1)
                    q11.push_back('{data: 64'(w11Data), injEn: w11InjEn, injPos: int'(w11InjPos)});
                if (wValid === 1'b1 && w26Ready === 1'b1)
                    q26.push_back('{data: 64'(w26Data), injEn: w26InjEn, injPos: int'(w26InjPos)});
                if (wValid === 1'b1 && w57Ready === 1'b1)
                    q57.push_back('{data: 64'(w57Data), injEn: w57InjEn, injPos: int'(w57InjPos)});
            end else begin
                holdActive = 0;
            end
        end
    end

    // Offer one word to the 4-bit instance and return just after the edge
    // that accepted it; gives up after a bounded number of cycles.
    task automatic applyStimulus(input logic [3:0] d, input logic s, input logic ie, input logic [IW4-1:0] ip);
        bit done;
        done      = 0;
        in_valid  = 1'b1;
        data_in   = d;
        secded_en = s;
        inj_en    = ie;
        inj_pos   = ip;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            if (in_ready === 1'b1) done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) checkOutput("acceptTimeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Directed sequence, then random traffic on the small instance and a
    // streaming run on the wide instances.
    initial begin
        int startCycle;
        reset     = 1'b1;
        in_valid  = 1'b0;
        data_in   = '0;
        secded_en = 1'b1;
        inj_en    = 1'b0;
        inj_pos   = '0;
        out_ready = 1'b0;
        wValid    = 1'b0;
        wSecded   = 1'b1;
        wOutReady = 1'b1;
        w11Data = '0; w11InjEn = 1'b0; w11InjPos = '0;
        w26Data = '0; w26InjEn = 1'b0; w26InjPos = '0;
        w57Data = '0; w57InjEn = 1'b0; w57InjPos = '0;

        idleCycles(3);
        checkOutput("resetInReady", 64'(in_ready), 64'd0);
        checkOutput("resetOutValid", 64'(out_valid), 64'd0);
        reset = 1'b0;
        idleCycles(1);
        checkOutput("inReadyAfterRelease", 64'(in_ready), 64'd1);

        checkOutput("modelAA", modelEncode(64'hB, 4, 1, 0, 0), 64'hAA);
        checkOutput("model0F", modelEncode(64'h1, 4, 1, 0, 0), 64'h0F);
        checkOutput("model0E", modelEncode(64'h1, 4, 0, 0, 0), 64'h0E);
        checkOutput("model8A", modelEncode(64'hB, 4, 1, 1, 5), 64'h8A);

        out_ready = 1'b1;
        applyStimulus(4'b1011, 1'b1, 1'b0, 4'd0);
        checkOutput("dirAAValid", 64'(out_valid), 64'd1);
        checkOutput("dirAA", 64'(code_out), 64'hAA);
        idleCycles(1);
        checkOutput("dirCntOne", 64'(word_cnt), 64'd1);

        applyStimulus(4'b0001, 1'b1, 1'b0, 4'd0);
        checkOutput("dir0F", 64'(code_out), 64'h0F);
        applyStimulus(4'b0001, 1'b0, 1'b0, 4'd0);
        checkOutput("dir0E", 64'(code_out), 64'h0E);
        applyStimulus(4'b1011, 1'b1, 1'b1, 4'd5);
        checkOutput("dirInj5", 64'(code_out), 64'h8A);
        applyStimulus(4'b1011, 1'b1, 1'b1, 4'd9);
        checkOutput("dirInj9", 64'(code_out), 64'hAA);
        applyStimulus(4'b1011, 1'b1, 1'b1, 4'd0);
        checkOutput("dirInj0", 64'(code_out), 64'hAB);
        idleCycles(2);

        out_ready = 1'b0;
        applyStimulus(4'h3, 1'b1, 1'b0, 4'd0);
        applyStimulus(4'h5, 1'b0, 1'b0, 4'd0);
        in_valid  = 1'b1;
        data_in   = 4'hC;
        secded_en = 1'b1;
        checkOutput("bpInReadyLow", 64'(in_ready), 64'd0);
        repeat (5) begin
            idleCycles(1);
            checkOutput("bpStallReady", 64'(in_ready), 64'd0);
            checkOutput("bpStallCode", 64'(code_out), 64'h3C);
        end
        out_ready = 1'b1;
        applyStimulus(4'hC, 1'b1, 1'b0, 4'd0);
        checkOutput("bpThirdCode", 64'(code_out), 64'hC3);
        idleCycles(3);
        checkOutput("bpDrained", 64'(expQ.size()), 64'd0);

        reset = 1'b1;
        idleCycles(1);
        checkOutput("pulseCnt", 64'(word_cnt), 64'd0);
        reset = 1'b0;
        idleCycles(1);
        startCycle = cycleCount;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(4'(i), 1'(i % 2), 1'b0, 4'd0);
        end
        checkOutput("throughput", 64'(cycleCount - startCycle), 64'd17);
        idleCycles(3);
        checkOutput("wrapCnt", 64'(word_cnt), 64'd1);

        out_ready = 1'b0;
        applyStimulus(4'h6, 1'b1, 1'b0, 4'd0);
        applyStimulus(4'h9, 1'b1, 1'b0, 4'd0);
        reset = 1'b1;
        idleCycles(1);
        checkOutput("midRstValid", 64'(out_valid), 64'd0);
        checkOutput("midRstCnt", 64'(word_cnt), 64'd0);
        checkOutput("midRstCode", 64'(code_out), 64'd0);
        reset = 1'b0;
        idleCycles(1);
        checkOutput("midRstReady", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        applyStimulus(4'hA, 1'b1, 1'b0, 4'd0);
        checkOutput("postRstCode", 64'(code_out), 64'hA5);
        idleCycles(1);
        checkOutput("postRstCnt", 64'(word_cnt), 64'd1);

        for (int i = 0; i < 150; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            data_in   = 4'($urandom);
            secded_en = 1'($urandom_range(0, 1));
            inj_en    = ($urandom_range(0, 3) == 0);
            inj_pos   = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            idleCycles(1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idleCycles(4);
        checkOutput("randDrained", 64'(expQ.size()), 64'd0);

        wValid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            w11Data   = 11'($urandom);
            w11InjEn  = 1'($urandom_range(0, 1));
            w11InjPos = 5'($urandom_range(0, 2 * CW11 - 1));
            w26Data   = 26'($urandom);
            w26InjEn  = 1'($urandom_range(0, 1));
            w26InjPos = 6'($urandom_range(0, 2 * CW26 - 1));
            w57Data   = 57'({$urandom, $urandom});
            w57InjEn  = 1'($urandom_range(0, 1));
            w57InjPos = 7'($urandom_range(0, 2 * CW57 - 1));
            idleCycles(1);
        end
        wValid = 1'b0;
        idleCycles(3);
        checkOutput("w11Drained", 64'(q11.size()), 64'd0);
        checkOutput("w26Drained", 64'(q26.size()), 64'd0);
        checkOutput("w57Drained", 64'(q57.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
